// File: rtl/cpu_bus_ctrl_pkg.sv
// Shared constants for the CPU bus controller: I/O window map, ID, timeout pattern, FSM states.
// No logic; imported by the controller and its I/O register block.
package cpu_bus_ctrl_pkg;

    localparam logic [31:0] IO_BASE_DEF = 32'hFFFF_0000;

    localparam logic [7:0]  OFF_ID      = 8'h00;
    localparam logic [7:0]  OFF_SCRATCH = 8'h04;
    localparam logic [7:0]  OFF_LEDS    = 8'h08;
    localparam logic [7:0]  OFF_CYCLES  = 8'h0C;
    localparam logic [7:0]  OFF_STATUS  = 8'h10;

    localparam logic [31:0] ID_VAL      = 32'h6583_2001;
    localparam logic [31:0] TMO_PATTERN = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IO      = 2'd1,
        ST_EXT     = 2'd2,
        ST_RELEASE = 2'd3
    } bus_state_e;

endpackage

// File: rtl/cpu_bus_ctrl_io_regs.sv
// Local I/O register window: ID, SCRATCH, LEDS, free-running CYCLES, sticky STATUS error.
// Latency: combinational read of current (pre-write) values; writes land on the strobe edge.
// Backpressure: none, every access completes in one cycle.
module bus_io_regs
    import cpu_bus_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [7:0]        i_offset,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_set_err,
    output logic [DATA_W-1:0] o_rdata,
    output logic [7:0]        o_leds,
    output logic              o_err
);

    logic [DATA_W-1:0] scratch_q, scratch_d;
    logic [7:0]        leds_q, leds_d;
    logic [31:0]       cycles_q, cycles_d;
    logic              err_q, err_d;

    always_comb begin
        scratch_d = scratch_q;
        leds_d    = leds_q;
        cycles_d  = cycles_q + 32'd1;
        err_d     = err_q;
        if (i_wr_en) begin
            case (i_offset)
                OFF_SCRATCH: scratch_d = i_wdata;
                OFF_LEDS:    leds_d    = i_wdata[7:0];
                OFF_CYCLES:  cycles_d  = 32'd0;
                OFF_STATUS:  if (i_wdata[0]) err_d = 1'b0;
                default:     ;
            endcase
        end
        // A timeout landing with a STATUS clear must not be lost.
        if (i_set_err) err_d = 1'b1;
    end

    always_comb begin
        o_rdata = '0;
        case (i_offset)
            OFF_ID:      o_rdata = DATA_W'(ID_VAL);
            OFF_SCRATCH: o_rdata = scratch_q;
            OFF_LEDS:    o_rdata = DATA_W'(leds_q);
            OFF_CYCLES:  o_rdata = DATA_W'(cycles_q);
            OFF_STATUS:  o_rdata = DATA_W'(err_q);
            default:     o_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scratch_q <= '0;
            leds_q    <= '0;
            cycles_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            leds_q    <= leds_d;
            cycles_q  <= cycles_d;
            err_q     <= err_d;
        end
    end

    assign o_leds = leds_q;
    assign o_err  = err_q;

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU bus controller: serves the I/O window locally, forwards other addresses to the ext req/ack port.
// Latency: I/O ready 2 edges after req is sampled; ext ready 1 edge after ack, else DEADBEEF after TIMEOUT.
// Backpressure: one transaction at a time; a held req is not re-accepted until it drops.
module cpu_bus_ctrl
    import cpu_bus_ctrl_pkg::*;
#(
    parameter int                   DATA_W  = 32,
    parameter int                   ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]    IO_BASE = ADDR_W'(IO_BASE_DEF),
    parameter int unsigned          TIMEOUT = 255
) (
    input  logic              i_cpu_clk,
    input  logic              i_rst,
    input  logic              i_bus_req,
    input  logic              i_bus_we,
    input  logic [ADDR_W-1:0] i_bus_addr,
    input  logic [DATA_W-1:0] i_bus_wdata,
    output logic [DATA_W-1:0] o_bus_rdata,
    output logic              o_bus_data_ready,
    output logic              o_ext_req,
    output logic              o_ext_we,
    output logic [ADDR_W-1:0] o_ext_addr,
    output logic [DATA_W-1:0] o_ext_wdata,
    input  logic [DATA_W-1:0] i_ext_rdata,
    input  logic              i_ext_ack,
    output logic [7:0]        o_leds,
    output logic              o_bus_err
);

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

    bus_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ext_req_q, ext_req_d;
    logic              rdy_q, rdy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [15:0]       tmo_cnt_q, tmo_cnt_d;

    logic              io_wr;
    logic              set_err;
    logic [DATA_W-1:0] io_rdata;

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ext_req_d = ext_req_q;
        tmo_cnt_d = tmo_cnt_q;
        rdy_d     = 1'b0;
        rdata_d   = '0;
        io_wr     = 1'b0;
        set_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_bus_req) begin
                    we_d      = i_bus_we;
                    addr_d    = i_bus_addr;
                    wdata_d   = i_bus_wdata;
                    tmo_cnt_d = '0;
                    state_d   = (i_bus_addr[ADDR_W-1:8] == IO_BASE[ADDR_W-1:8]) ? ST_IO : ST_EXT;
                end
            end
            ST_IO: begin
                io_wr   = we_q;
                rdy_d   = 1'b1;
                rdata_d = io_rdata;
                state_d = ST_RELEASE;
            end
            ST_EXT: begin
                // Ack only counts once the request is visible on the port; it outranks a timeout.
                if (ext_req_q && i_ext_ack) begin
                    ext_req_d = 1'b0;
                    rdy_d     = 1'b1;
                    rdata_d   = we_q ? '0 : i_ext_rdata;
                    state_d   = ST_RELEASE;
                end else if (tmo_cnt_q == TMO_LIMIT) begin
                    ext_req_d = 1'b0;
                    rdy_d     = 1'b1;
                    rdata_d   = DATA_W'(TMO_PATTERN);
                    set_err   = 1'b1;
                    state_d   = ST_RELEASE;
                end else begin
                    ext_req_d = 1'b1;
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            ST_RELEASE: begin
                if (!i_bus_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_cpu_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ext_req_q <= 1'b0;
            tmo_cnt_q <= '0;
            rdy_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ext_req_q <= ext_req_d;
            tmo_cnt_q <= tmo_cnt_d;
            rdy_q     <= rdy_d;
            rdata_q   <= rdata_d;
        end
    end

    bus_io_regs #(
        .DATA_W (DATA_W)
    ) u_io_regs (
        .i_clk     (i_cpu_clk),
        .i_rst     (i_rst),
        .i_wr_en   (io_wr),
        .i_offset  (addr_q[7:0]),
        .i_wdata   (wdata_q),
        .i_set_err (set_err),
        .o_rdata   (io_rdata),
        .o_leds    (o_leds),
        .o_err     (o_bus_err)
    );

    assign o_bus_rdata      = rdata_q;
    assign o_bus_data_ready = rdy_q;
    assign o_ext_req        = ext_req_q;
    assign o_ext_we         = we_q;
    assign o_ext_addr       = addr_q;
    assign o_ext_wdata      = wdata_q;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Self-checking bench for cpu_bus_ctrl: vector table plus hand sequences, rdata checked via scoreboard queue.
module tb_cpu_bus_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_bus_req = 1'b0;
    logic        i_bus_we = 1'b0;
    logic [31:0] i_bus_addr = '0;
    logic [31:0] i_bus_wdata = '0;
    logic [31:0] o_bus_rdata;
    logic        o_bus_data_ready;
    logic        o_ext_req;
    logic        o_ext_we;
    logic [31:0] o_ext_addr;
    logic [31:0] o_ext_wdata;
    logic [31:0] i_ext_rdata = '0;
    logic        i_ext_ack = 1'b0;
    logic [7:0]  o_leds;
    logic        o_bus_err;

    always #5 clk = ~clk;

    cpu_bus_ctrl #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .IO_BASE (32'hFFFF_0000),
        .TIMEOUT (TMO)
    ) dut (
        .i_cpu_clk        (clk),
        .i_rst            (i_rst),
        .i_bus_req        (i_bus_req),
        .i_bus_we         (i_bus_we),
        .i_bus_addr       (i_bus_addr),
        .i_bus_wdata      (i_bus_wdata),
        .o_bus_rdata      (o_bus_rdata),
        .o_bus_data_ready (o_bus_data_ready),
        .o_ext_req        (o_ext_req),
        .o_ext_we         (o_ext_we),
        .o_ext_addr       (o_ext_addr),
        .o_ext_wdata      (o_ext_wdata),
        .i_ext_rdata      (i_ext_rdata),
        .i_ext_ack        (i_ext_ack),
        .o_leds           (o_leds),
        .o_bus_err        (o_bus_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_dly;     // cycles after ext_req is first seen; -1 = never ack
        logic [31:0] ext_rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [7:0]  exp_leds;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          care;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   prev_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard side: every ready pulse must match the oldest outstanding transaction.
    always @(negedge clk) begin
        exp_t e;
        if (o_bus_data_ready) begin
            check("ready_not_back_to_back", 32'(prev_rdy), 32'd0);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ready: rdata %h with no transaction outstanding", o_bus_rdata);
            end else begin
                e = sb.pop_front();
                if (e.care) check("rdata", o_bus_rdata, e.rdata);
            end
        end
        prev_rdy = o_bus_data_ready;
    end

    task automatic do_txn(input vec_t v, input bit care, input string name);
        int first_seen = -1;
        int lat = -1;
        int exp_lat;
        bit io;
        io      = (v.addr[31:8] == 24'hFFFF00);
        exp_lat = io ? 2 : ((v.ack_dly >= 0) ? v.ack_dly + 3 : TMO + 2);
        sb.push_back('{v.exp_rdata, care});
        i_bus_req   = 1'b1;
        i_bus_we    = v.we;
        i_bus_addr  = v.addr;
        i_bus_wdata = v.wdata;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            i_ext_ack = 1'b0;
            if (o_ext_req && first_seen < 0) begin
                first_seen = i;
                if (!io) begin
                    check({name, "_ext_addr"}, o_ext_addr, v.addr);
                    check({name, "_ext_we"}, 32'(o_ext_we), 32'(v.we));
                    check({name, "_ext_req_start"}, 32'(i), 32'd2);
                end
            end
            if (o_bus_data_ready) begin
                lat = i;
                break;
            end
            if (!io && first_seen >= 0 && v.ack_dly >= 0 && i == first_seen + v.ack_dly) begin
                i_ext_ack   = 1'b1;
                i_ext_rdata = v.ext_rdata;
            end
        end
        if (lat < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no ready within 40 cycles", name);
        end else begin
            check({name, "_latency"}, 32'(lat), 32'(exp_lat));
            check({name, "_ext_req_low"}, 32'(o_ext_req), 32'd0);
            check({name, "_err"}, 32'(o_bus_err), 32'(v.exp_err));
            check({name, "_leds"}, 32'(o_leds), 32'(v.exp_leds));
        end
        if (io) check({name, "_no_ext_req"}, 32'(first_seen >= 0), 32'd0);
        i_bus_req = 1'b0;
        i_ext_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[15];
        vec_t h;
        int   pulses;
        bit   got_req;

        //             we    addr            wdata          ack  ext_rdata      exp_rdata      err   leds
        vt[0]  = '{1'b0, 32'hFFFF_0000, 32'h0,         -1, 32'h0,         32'h6583_2001, 1'b0, 8'h00};
        vt[1]  = '{1'b1, 32'hFFFF_0008, 32'h0000_00A5, -1, 32'h0,         32'h0000_0000, 1'b0, 8'hA5};
        vt[2]  = '{1'b0, 32'hFFFF_0008, 32'h0,         -1, 32'h0,         32'h0000_00A5, 1'b0, 8'hA5};
        vt[3]  = '{1'b1, 32'hFFFF_0004, 32'hCAFE_F00D, -1, 32'h0,         32'h0000_0000, 1'b0, 8'hA5};
        vt[4]  = '{1'b0, 32'hFFFF_0004, 32'h0,         -1, 32'h0,         32'hCAFE_F00D, 1'b0, 8'hA5};
        vt[5]  = '{1'b0, 32'hFFFF_0014, 32'h0,         -1, 32'h0,         32'h0000_0000, 1'b0, 8'hA5};
        vt[6]  = '{1'b1, 32'hFFFF_0020, 32'h1111_1111, -1, 32'h0,         32'h0000_0000, 1'b0, 8'hA5};
        vt[7]  = '{1'b1, 32'hFFFF_0000, 32'h5555_5555, -1, 32'h0,         32'h6583_2001, 1'b0, 8'hA5};
        vt[8]  = '{1'b0, 32'h0001_0000, 32'h0,          2, 32'h1234_5678, 32'h1234_5678, 1'b0, 8'hA5};
        vt[9]  = '{1'b1, 32'h0001_0004, 32'h7777_0000,  0, 32'h9999_9999, 32'h0000_0000, 1'b0, 8'hA5};
        vt[10] = '{1'b0, 32'h0003_0010, 32'h0,          3, 32'hA1B2_C3D4, 32'hA1B2_C3D4, 1'b0, 8'hA5};
        vt[11] = '{1'b1, 32'h0001_0008, 32'hFEED_0001, -1, 32'h0,         32'hDEAD_BEEF, 1'b1, 8'hA5};
        vt[12] = '{1'b0, 32'hFFFF_0010, 32'h0,         -1, 32'h0,         32'h0000_0001, 1'b1, 8'hA5};
        vt[13] = '{1'b1, 32'hFFFF_0010, 32'h0000_0001, -1, 32'h0,         32'h0000_0001, 1'b0, 8'hA5};
        vt[14] = '{1'b0, 32'hFFFF_0010, 32'h0,         -1, 32'h0,         32'h0000_0000, 1'b0, 8'hA5};

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(o_bus_data_ready), 32'd0);
        check("rst_rdata", o_bus_rdata, 32'd0);
        check("rst_ext_req", 32'(o_ext_req), 32'd0);
        check("rst_ext_we", 32'(o_ext_we), 32'd0);
        check("rst_ext_addr", o_ext_addr, 32'd0);
        check("rst_ext_wdata", o_ext_wdata, 32'd0);
        check("rst_leds", 32'(o_leds), 32'd0);
        check("rst_err", 32'(o_bus_err), 32'd0);
        i_rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 15; k++) do_txn(vt[k], 1'b1, $sformatf("vec%0d", k));

        // Request held high for 10 cycles: one completion only; stray acks outside EXT do nothing.
        sb.push_back('{32'h6583_2001, 1'b1});
        i_bus_req  = 1'b1;
        i_bus_we   = 1'b0;
        i_bus_addr = 32'hFFFF_0000;
        pulses     = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (o_bus_data_ready) pulses++;
            i_ext_ack = (i == 5 || i == 6);
        end
        check("hold_req_pulses", 32'(pulses), 32'd1);
        i_bus_req = 1'b0;
        i_ext_ack = 1'b0;
        @(negedge clk);
        h = '{1'b0, 32'hFFFF_0000, 32'h0, -1, 32'h0, 32'h6583_2001, 1'b0, 8'hA5};
        do_txn(h, 1'b1, "rearm");

        // CYCLES write clears the counter; 2 increments pass before the back-to-back read samples it.
        h = '{1'b1, 32'hFFFF_000C, 32'hFFFF_FFFF, -1, 32'h0, 32'h0, 1'b0, 8'hA5};
        do_txn(h, 1'b0, "cycles_wr");
        h = '{1'b0, 32'hFFFF_000C, 32'h0, -1, 32'h0, 32'h0000_0002, 1'b0, 8'hA5};
        do_txn(h, 1'b1, "cycles_rd");

        // Reset in the middle of an external access: no ready, everything back to reset values.
        i_bus_req  = 1'b1;
        i_bus_we   = 1'b0;
        i_bus_addr = 32'h0002_0000;
        got_req    = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (o_ext_req) begin
                got_req = 1'b1;
                break;
            end
        end
        check("midrst_ext_req_seen", 32'(got_req), 32'd1);
        i_rst = 1'b1;
        @(negedge clk);
        check("midrst_ext_req", 32'(o_ext_req), 32'd0);
        check("midrst_ready", 32'(o_bus_data_ready), 32'd0);
        check("midrst_ext_addr", o_ext_addr, 32'd0);
        check("midrst_leds", 32'(o_leds), 32'd0);
        i_rst     = 1'b0;
        i_bus_req = 1'b0;
        repeat (3) @(negedge clk);
        h = '{1'b0, 32'hFFFF_0008, 32'h0, -1, 32'h0, 32'h0000_0000, 1'b0, 8'h00};
        do_txn(h, 1'b1, "post_rst");

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
